// File: rtl/ppu_pkg.sv
// ppu_pkg: shared types and constants for the CPU-to-PPU register bridge.
//   reg_t     - PPU register selector (PPUCTRL..PPUDATA mirror slots, OAMDMA)
//   bridge_st_t - bridge FSM states
//   *_DEF     - default decode addresses
package ppu_pkg;

  typedef enum logic [3:0] {
    PPUCTRL   = 4'd0,
    PPUMASK   = 4'd1,
    PPUSTATUS = 4'd2,
    OAMADDR   = 4'd3,
    OAMDATA   = 4'd4,
    PPUSCROLL = 4'd5,
    PPUADDR   = 4'd6,
    PPUDATA   = 4'd7,
    OAMDMA    = 4'd8
  } reg_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_HOLD = 2'd1,
    RD_HOLD = 2'd2
  } bridge_st_t;

  localparam logic [15:0] PPU_BASE_DEF  = 16'h2000;
  localparam logic [15:0] PPU_LIMIT_DEF = 16'h3FFF;
  localparam logic [15:0] DMA_ADDR_DEF  = 16'h4014;

  // Registers whose reads return live PPU data; all others return open bus.
  function automatic logic reg_is_readable(input reg_t r);
    return (r == PPUSTATUS) || (r == OAMDATA) || (r == PPUDATA);
  endfunction

endpackage

// File: rtl/ppu_addr_decode.sv
// ppu_addr_decode: combinational decode of a CPU access into a PPU register access.
//   cpu_addr/cpu_re/cpu_we - CPU bus request
//   hit                    - access targets the PPU window or an OAMDMA write
//   sel                    - selected PPU register
//   is_write               - access is a write (write wins over simultaneous read)
module ppu_addr_decode
  import ppu_pkg::*;
#(
  parameter logic [15:0] PPU_BASE  = PPU_BASE_DEF,
  parameter logic [15:0] PPU_LIMIT = PPU_LIMIT_DEF,
  parameter logic [15:0] DMA_ADDR  = DMA_ADDR_DEF
) (
  input  logic [15:0] cpu_addr,
  input  logic        cpu_re,
  input  logic        cpu_we,
  output logic        hit,
  output reg_t        sel,
  output logic        is_write
);

  logic in_window;
  logic dma_wr;

  always_comb begin
    in_window = (cpu_addr >= PPU_BASE) && (cpu_addr <= PPU_LIMIT);
    dma_wr    = (cpu_addr == DMA_ADDR) && cpu_we;
    is_write  = cpu_we;
    hit       = (cpu_re || cpu_we) && (in_window || dma_wr);
    sel       = in_window ? reg_t'({1'b0, cpu_addr[2:0]}) : OAMDMA;
  end

endmodule

// File: rtl/ppu_cpu_bridge.sv
// ppu_cpu_bridge: CPU-side initiator for the PPU register port.
//   clk, rst_n           - system clock, async active-low reset
//   cpu_clk_en           - one-clk pulse per CPU cycle; all state advances on it
//   cpu_addr/re/we/wr_data - CPU bus request
//   cpu_rd_data/rd_valid - read return, one CPU cycle after issue
//   ppu_hit              - last sampled access decoded to the PPU
//   cpu_cyc_par          - CPU cycle parity
//   reg_sel/en/rw/data_in - PPU register request, held for a full CPU cycle
//   reg_data_out         - PPU read data
module ppu_cpu_bridge
  import ppu_pkg::*;
#(
  parameter logic [15:0] PPU_BASE  = PPU_BASE_DEF,
  parameter logic [15:0] PPU_LIMIT = PPU_LIMIT_DEF,
  parameter logic [15:0] DMA_ADDR  = DMA_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_clk_en,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_re,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_wr_data,
  output logic [7:0]  cpu_rd_data,
  output logic        cpu_rd_valid,
  output logic        ppu_hit,
  output logic        cpu_cyc_par,
  output reg_t        reg_sel,
  output logic        reg_en,
  output logic        reg_rw,
  output logic [7:0]  reg_data_in,
  input  logic [7:0]  reg_data_out
);

  bridge_st_t state_q, state_d;
  reg_t       reg_sel_q, reg_sel_d;
  logic       reg_en_q, reg_en_d;
  logic       reg_rw_q, reg_rw_d;
  logic [7:0] reg_data_in_q, reg_data_in_d;
  logic [7:0] cpu_rd_data_q, cpu_rd_data_d;
  logic       cpu_rd_valid_q, cpu_rd_valid_d;
  logic       ppu_hit_q, ppu_hit_d;
  logic       cpu_cyc_par_q, cpu_cyc_par_d;
  logic [7:0] open_bus_q, open_bus_d;

  logic       dec_hit;
  reg_t       dec_sel;
  logic       dec_wr;
  logic [7:0] ret_val;

  ppu_addr_decode #(
    .PPU_BASE  (PPU_BASE),
    .PPU_LIMIT (PPU_LIMIT),
    .DMA_ADDR  (DMA_ADDR)
  ) u_decode (
    .cpu_addr (cpu_addr),
    .cpu_re   (cpu_re),
    .cpu_we   (cpu_we),
    .hit      (dec_hit),
    .sel      (dec_sel),
    .is_write (dec_wr)
  );

  always_comb begin
    state_d        = state_q;
    reg_sel_d      = reg_sel_q;
    reg_en_d       = reg_en_q;
    reg_rw_d       = reg_rw_q;
    reg_data_in_d  = reg_data_in_q;
    cpu_rd_data_d  = cpu_rd_data_q;
    cpu_rd_valid_d = 1'b0;
    ppu_hit_d      = ppu_hit_q;
    cpu_cyc_par_d  = cpu_cyc_par_q;
    open_bus_d     = open_bus_q;
    ret_val        = reg_is_readable(reg_sel_q) ? reg_data_out : open_bus_q;

    if (cpu_clk_en) begin
      cpu_cyc_par_d = ~cpu_cyc_par_q;

      // Return of the held read shares the edge with the next issue; a hit
      // write on the same edge is later on the bus and wins the open-bus latch.
      if (state_q == RD_HOLD) begin
        cpu_rd_data_d  = ret_val;
        cpu_rd_valid_d = 1'b1;
        open_bus_d     = ret_val;
      end

      if (dec_hit) begin
        reg_sel_d = dec_sel;
        reg_rw_d  = dec_wr;
        reg_en_d  = 1'b1;
        ppu_hit_d = 1'b1;
        if (dec_wr) begin
          reg_data_in_d = cpu_wr_data;
          open_bus_d    = cpu_wr_data;
          state_d       = WR_HOLD;
        end else begin
          state_d = RD_HOLD;
        end
      end else begin
        reg_en_d  = 1'b0;
        ppu_hit_d = 1'b0;
        state_d   = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      reg_sel_q      <= PPUCTRL;
      reg_en_q       <= 1'b0;
      reg_rw_q       <= 1'b0;
      reg_data_in_q  <= '0;
      cpu_rd_data_q  <= '0;
      cpu_rd_valid_q <= 1'b0;
      ppu_hit_q      <= 1'b0;
      cpu_cyc_par_q  <= 1'b0;
      open_bus_q     <= '0;
    end else begin
      state_q        <= state_d;
      reg_sel_q      <= reg_sel_d;
      reg_en_q       <= reg_en_d;
      reg_rw_q       <= reg_rw_d;
      reg_data_in_q  <= reg_data_in_d;
      cpu_rd_data_q  <= cpu_rd_data_d;
      cpu_rd_valid_q <= cpu_rd_valid_d;
      ppu_hit_q      <= ppu_hit_d;
      cpu_cyc_par_q  <= cpu_cyc_par_d;
      open_bus_q     <= open_bus_d;
    end
  end

  assign reg_sel      = reg_sel_q;
  assign reg_en       = reg_en_q;
  assign reg_rw       = reg_rw_q;
  assign reg_data_in  = reg_data_in_q;
  assign cpu_rd_data  = cpu_rd_data_q;
  assign cpu_rd_valid = cpu_rd_valid_q;
  assign ppu_hit      = ppu_hit_q;
  assign cpu_cyc_par  = cpu_cyc_par_q;

endmodule
